pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
Controller that sequences the SWIPT PLL2 loop from power-up to lock. It drives the PLL's swiptAlive and freq_rdy inputs, runs a fixed-frequency preset phase, then releases the loop. It qualifies lock from the measured phase error and the output frequency f, and handles acquisition timeout, bounded retry, loss-of-lock and fault. It sits between the system control FSM and the PLL2 instance.

Parameters:
W, 32, width of phase error, frequency and timeout counters
PRESET_CYC, 2816, cycles freq_rdy is held high (fixed-f0 VCO) before the loop is released
LOCK_TOL, 16, max phase_err magnitude (clk cycles) counted as in-window
LOCK_COUNT, 8, consecutive in-window samples required to declare lock
UNLOCK_COUNT, 4, consecutive out-of-window samples in LOCKED that declare loss
ACQ_TIMEOUT, 1000000, max cycles in ACQUIRE before a retry
MAX_RETRY, 3, failed acquisitions tolerated before FAULT
F_MIN, 30000, lowest f accepted as valid (Hz)
F_MAX, 50000, highest f accepted as valid (Hz)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
enable  in  1  level request to run the PLL
link_present  in  1  carrier detected on link input
phase_err  in  W  unsigned phase-error pulse length from the PLL
phase_err_valid  in  1  one-cycle strobe, phase_err sample is valid
f_meas  in  W  current PLL output frequency f
pll_alive  out  1  drives PLL swiptAlive
freq_rdy  out  1  drives PLL freq_rdy (1 = fixed-f0 VCO)
locked  out  1  lock indication
lock_lost  out  1  one-cycle pulse on LOCKED->PRESET exit
fault  out  1  sticky fault flag
state  out  3  IDLE=0, PRESET=1, ACQUIRE=2, LOCKED=3, FAULT=4
retry_cnt  out  2  failed acquisitions since the last lock

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, all outputs 0, all counters 0.
- All outputs are registered and reflect the current state. Each transition takes effect on the following clk edge.
- Sample qualifier: good = phase_err_valid & (phase_err <= LOCK_TOL) & (F_MIN <= f_meas <= F_MAX). bad = phase_err_valid & ~good. Cycles with no valid strobe leave the run counters unchanged.
- Abort: enable=0 or link_present=0 in any state except FAULT -> IDLE. This clears the counters and retry_cnt. Abort has priority over every other transition.
- IDLE: pll_alive=0, freq_rdy=0. Goes to PRESET when enable & link_present.
- PRESET: pll_alive=1, freq_rdy=1. The cycle counter loads 0 on entry. Goes to ACQUIRE when the counter reaches PRESET_CYC-1, so the state lasts exactly PRESET_CYC cycles.
- ACQUIRE: pll_alive=1, freq_rdy=0. The timeout counter and good-run counter load 0 on entry.
  - good increments the run counter. bad clears it.
  - Run counter reaches LOCK_COUNT -> LOCKED. retry_cnt clears.
  - Otherwise, timeout counter reaches ACQ_TIMEOUT-1: if retry_cnt==MAX_RETRY -> FAULT; else retry_cnt+1 and -> PRESET.
  - Lock completion and timeout in the same cycle: lock wins.
- LOCKED: locked=1, pll_alive=1, freq_rdy=0.
  - bad increments the bad-run counter. good clears it.
  - Counter reaches UNLOCK_COUNT -> PRESET with lock_lost=1 for one cycle. retry_cnt is unchanged.
- FAULT: fault=1, pll_alive=0, freq_rdy=0. Sticky. Exits to IDLE only when enable=0; link_present is ignored. A new run requires enable to rise again.
- Counters saturate and never wrap. retry_cnt width is fixed at 2, so MAX_RETRY must be <= 3.
- Reset asserted mid-operation forces IDLE immediately. pll_alive drops asynchronously.

Test Plan:
1. Params PRESET_CYC=4, LOCK_COUNT=3. Raise enable & link_present, then 3 strobes with phase_err=5, f_meas=41000 -> freq_rdy high exactly 4 cycles, locked=1 one cycle after the 3rd strobe, retry_cnt=0.
2. In ACQUIRE, strobes with phase_err 5,5,40,5,5,5 -> the run resets at 40; locked rises after the final 5. Repeat with f_meas=60000 -> never locks.
3. ACQ_TIMEOUT=20, MAX_RETRY=2, no good strobes -> PRESET re-entered twice (retry_cnt 1, 2), then FAULT with fault=1 and pll_alive=0. Toggling link_present has no effect; enable=0 -> IDLE with fault=0.
4. From LOCKED, UNLOCK_COUNT=4 bad strobes interleaved with one good after the 2nd -> stays locked. Then 4 consecutive bad -> lock_lost pulses for 1 cycle, state=PRESET.
5. Drop link_present mid-ACQUIRE -> IDLE next edge, all outputs 0. Assert nrst=0 mid-LOCKED -> locked and pll_alive fall without a clk edge.
6. Timeout cycle coincides with the LOCK_COUNT-th good strobe -> LOCKED, retry_cnt unchanged/cleared, no PRESET.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: control/status bundle between the system FSM side and the PLL lock sequencer.
// master: system side (drives enable, link_present, PLL measurements; observes status)
// slave : sequencer side (observes requests/measurements; drives PLL controls and status)
//   enable, link_present      run request and carrier-present level
//   phase_err/_valid, f_meas  PLL phase-error sample with strobe, measured output frequency
//   pll_alive, freq_rdy       PLL swiptAlive and freq_rdy controls
//   locked, lock_lost, fault  lock level, loss-of-lock pulse, sticky fault
//   state, retry_cnt          current sequencer state, failed acquisitions since last lock
interface pll_lock_sequencer_if #(
    parameter int W = 32
);
    logic         enable;
    logic         link_present;
    logic [W-1:0] phase_err;
    logic         phase_err_valid;
    logic [W-1:0] f_meas;
    logic         pll_alive;
    logic         freq_rdy;
    logic         locked;
    logic         lock_lost;
    logic         fault;
    logic [2:0]   state;
    logic [1:0]   retry_cnt;

    modport master (
        output enable, link_present, phase_err, phase_err_valid, f_meas,
        input  pll_alive, freq_rdy, locked, lock_lost, fault, state, retry_cnt
    );

    modport slave (
        input  enable, link_present, phase_err, phase_err_valid, f_meas,
        output pll_alive, freq_rdy, locked, lock_lost, fault, state, retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences the PLL2 loop from power-up through fixed-f0 preset, acquisition and lock.
// clk  : system clock
// nrst : asynchronous active-low reset (forces IDLE, all outputs low)
// bus  : slave side of pll_lock_sequencer_if (requests and PLL measurements in, PLL controls and status out)
module pll_lock_sequencer #(
    parameter int W            = 32,
    parameter int PRESET_CYC   = 2816,
    parameter int LOCK_TOL     = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int ACQ_TIMEOUT  = 1000000,
    parameter int MAX_RETRY    = 3,
    parameter int F_MIN        = 30000,
    parameter int F_MAX        = 50000
) (
    input logic                 clk,
    input logic                 nrst,
    pll_lock_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESET  = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [W-1:0] PRESET_LAST = W'(PRESET_CYC - 1);
    localparam logic [W-1:0] ACQ_LAST    = W'(ACQ_TIMEOUT - 1);
    localparam logic [W-1:0] TOL         = W'(LOCK_TOL);
    localparam logic [W-1:0] FMIN        = W'(F_MIN);
    localparam logic [W-1:0] FMAX        = W'(F_MAX);
    localparam logic [W-1:0] LOCK_N      = W'(LOCK_COUNT);
    localparam logic [W-1:0] UNLOCK_N    = W'(UNLOCK_COUNT);
    localparam logic [1:0]   RETRY_MAX   = 2'(MAX_RETRY);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d, run_q, run_d, cnt_inc, run_inc;
    logic [1:0]   retry_q, retry_d;
    logic         lock_lost_q, lock_lost_d;
    logic         pll_alive_q, freq_rdy_q, locked_q, fault_q;
    logic         good, bad, abort;

    assign good    = bus.phase_err_valid && (bus.phase_err <= TOL) && (bus.f_meas >= FMIN) && (bus.f_meas <= FMAX);
    assign bad     = bus.phase_err_valid && !good;
    assign abort   = !bus.enable || !bus.link_present;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign run_inc = (run_q == '1) ? run_q : run_q + 1'b1;

    // cnt_q is the PRESET cycle counter or the ACQUIRE timeout counter; run_q is the
    // good-run counter in ACQUIRE or the bad-run counter in LOCKED.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = PRESET;
                cnt_d   = '0;
                run_d   = '0;
            end
            PRESET: begin
                cnt_d   = (cnt_q == PRESET_LAST) ? '0 : cnt_inc;
                run_d   = '0;
                state_d = (cnt_q == PRESET_LAST) ? ACQUIRE : PRESET;
            end
            ACQUIRE: begin
                run_d = good ? run_inc : (bad ? '0 : run_q);
                cnt_d = cnt_inc;
                // Lock completion takes precedence over a coinciding timeout.
                if (run_d == LOCK_N) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == ACQ_LAST) begin
                    cnt_d   = '0;
                    run_d   = '0;
                    state_d = (retry_q == RETRY_MAX) ? FAULT : PRESET;
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;
                end
            end
            LOCKED: begin
                run_d = bad ? run_inc : (good ? '0 : run_q);
                if (run_d == UNLOCK_N) begin
                    state_d     = PRESET;
                    run_d       = '0;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end
            end
            FAULT: begin
                // Sticky until enable drops; link_present is deliberately ignored here.
                if (!bus.enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    run_d   = '0;
                    retry_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != FAULT) begin
            state_d     = IDLE;
            cnt_d       = '0;
            run_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they are registered yet track state_q exactly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            pll_alive_q <= 1'b0;
            freq_rdy_q  <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            pll_alive_q <= (state_d == PRESET) || (state_d == ACQUIRE) || (state_d == LOCKED);
            freq_rdy_q  <= (state_d == PRESET);
            locked_q    <= (state_d == LOCKED);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.pll_alive = pll_alive_q;
    assign bus.freq_rdy  = freq_rdy_q;
    assign bus.locked    = locked_q;
    assign bus.fault     = fault_q;
endmodule
